// File: rtl/fir_coef_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fir_coef_bank_ctrl
// Description : Double-buffered coefficient bank for the 16-tap Q1.15 FIR.
//               Optional build macro: FIR_COEF_SYM_EN (symmetric tap writes).
// Revision    : 1.0 - initial release
// ============================================================================
module fir_coef_bank_ctrl #(
    parameter int TAPS     = 16,
    parameter int CW       = 16,
    parameter int PIPE_LAT = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [$clog2(TAPS)-1:0] wr_addr,
    input  logic [CW-1:0]           wr_data,
    output logic                    wr_ready,
    input  logic                    commit,
    input  logic                    sample_stb,
    output logic [TAPS*CW-1:0]      coef_flat,
    output logic                    swap_pulse,
    output logic                    out_valid,
    output logic                    busy,
    output logic                    err
);

    localparam int                c_AW         = $clog2(TAPS);
    localparam int                c_CNTW       = $clog2(PIPE_LAT + 1);
    localparam logic [c_CNTW-1:0] c_FLUSH_INIT = c_CNTW'(PIPE_LAT);
    localparam logic [c_CNTW-1:0] c_CNT_LAST   = c_CNTW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PEND  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [TAPS-1:0][CW-1:0] r_shadow;
    logic [TAPS-1:0][CW-1:0] r_active;
    logic [TAPS-1:0]         r_mask;
    logic [TAPS-1:0]         w_wr_bits;
    logic [TAPS-1:0]         w_mask_wr;
    logic [c_CNTW-1:0]       r_cnt;
    logic                    r_swap_pulse;
    logic                    r_out_valid;
    logic                    r_err;
    logic                    w_idle;
    logic                    w_addr_ok;
    logic                    w_mask_full;
    logic                    w_wr_ok;
    logic                    w_wr_reject;
    logic                    w_commit_ok;
    logic                    w_commit_bad;
    logic                    w_swap;
    logic                    w_flush_done;

    assign w_idle      = (r_state == S_IDLE);
    assign w_wr_ok     = w_idle & wr_en & w_addr_ok;
    assign w_wr_reject = wr_en & ~(w_idle & w_addr_ok);

`ifdef FIR_COEF_SYM_EN
    // Only the lower half is host-addressable; each write mirrors to TAPS-1-k (= ~k).
    assign w_addr_ok   = ~wr_addr[c_AW-1];
    assign w_wr_bits   = w_wr_ok ? ((TAPS'(1) << wr_addr) | (TAPS'(1) << ~wr_addr)) : '0;
    assign w_mask_full = &w_mask_wr[TAPS/2-1:0];
`else
    assign w_addr_ok   = 1'b1;
    assign w_wr_bits   = w_wr_ok ? (TAPS'(1) << wr_addr) : '0;
    assign w_mask_full = &w_mask_wr;
`endif

    // Completeness includes a write landing in the same cycle as the commit.
    assign w_mask_wr = r_mask | w_wr_bits;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_commit_ok  = 1'b0;
        w_commit_bad = 1'b0;
        w_swap       = 1'b0;
        w_flush_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (commit) begin
                    if (w_mask_full) begin
                        w_commit_ok = 1'b1;
                        w_state_nxt = S_PEND;
                    end else begin
                        w_commit_bad = 1'b1;
                    end
                end
            end
            S_PEND: begin
                if (sample_stb) begin
                    w_swap      = 1'b1;
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_flush_done = 1'b1;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow     <= '0;
            r_active     <= '0;
            r_mask       <= '0;
            r_cnt        <= '0;
            r_swap_pulse <= 1'b0;
            r_out_valid  <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            for (int k = 0; k < TAPS; k++) begin
                if (w_wr_bits[k]) begin
                    r_shadow[k] <= wr_data;
                end
            end
            r_mask <= w_commit_ok ? '0 : w_mask_wr;

            if (w_swap) begin
                r_active <= r_shadow;
            end
            r_swap_pulse <= w_swap;

            if (w_swap) begin
                r_cnt <= c_FLUSH_INIT;
            end else if (w_flush_done) begin
                r_cnt <= '0;
            end else if (r_state == S_FLUSH) begin
                r_cnt <= r_cnt - c_CNT_LAST;
            end

            // Qualifier stays low until products from the old bank have drained.
            if (w_swap) begin
                r_out_valid <= 1'b0;
            end else if (w_flush_done) begin
                r_out_valid <= 1'b1;
            end

            if (w_wr_reject | w_commit_bad) begin
                r_err <= 1'b1;
            end else if (w_commit_ok) begin
                r_err <= 1'b0;
            end
        end
    end

    assign coef_flat  = r_active;
    assign swap_pulse = r_swap_pulse;
    assign out_valid  = r_out_valid;
    assign err        = r_err;
    assign wr_ready   = w_idle;
    assign busy       = ~w_idle;

endmodule
`default_nettype wire
